keycode_encoder: RTL and testbench

KEYCODE_ENCODER -- requirements
Module: keycode_encoder

---
 rtl/contra_input_pkg.sv | 80 ++++++++
 rtl/keycode_encoder_if.sv | 26 ++
 rtl/ps2_prefix_parser.sv | 76 +++++++
 rtl/keycode_encoder.sv | 111 +++++++++++
 tb/tb_keycode_encoder.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/contra_input_pkg.sv
`default_nettype none
// ============================================================================
// Module      : contra_input_pkg
// Description : Shared constants and types for PS/2 keyboard-to-game decoding.
// Revision    : 1.0 - initial release
// ============================================================================
package contra_input_pkg;

    localparam logic [7:0] c_SC_W     = 8'h1D;
    localparam logic [7:0] c_SC_A     = 8'h1C;
    localparam logic [7:0] c_SC_S     = 8'h1B;
    localparam logic [7:0] c_SC_D     = 8'h23;
    localparam logic [7:0] c_SC_SPACE = 8'h29;
    localparam logic [7:0] c_SC_J     = 8'h3B;
    localparam logic [7:0] c_SC_UP    = 8'h75;
    localparam logic [7:0] c_SC_LEFT  = 8'h6B;
    localparam logic [7:0] c_SC_DOWN  = 8'h72;
    localparam logic [7:0] c_SC_RIGHT = 8'h74;

    localparam logic [7:0] c_PFX_F0 = 8'hF0;
    localparam logic [7:0] c_PFX_E0 = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BREAK     = 2'd1,
        ST_EXT       = 2'd2,
        ST_EXT_BREAK = 2'd3
    } prefix_state_t;

    localparam logic [3:0] c_KC_NONE  = 4'd0;
    localparam logic [3:0] c_KC_UP    = 4'd1;
    localparam logic [3:0] c_KC_LEFT  = 4'd2;
    localparam logic [3:0] c_KC_DOWN  = 4'd3;
    localparam logic [3:0] c_KC_RIGHT = 4'd4;
    localparam logic [3:0] c_KC_UL    = 4'd5;
    localparam logic [3:0] c_KC_UR    = 4'd6;
    localparam logic [3:0] c_KC_DL    = 4'd7;
    localparam logic [3:0] c_KC_DR    = 4'd8;

    localparam logic [1:0] c_GS_PLAY = 2'b01;

    typedef struct packed {
        logic up_a;
        logic up_l;
        logic left_a;
        logic left_l;
        logic down_a;
        logic down_l;
        logic right_a;
        logic right_l;
        logic jump;
        logic shoot;
    } held_flags_t;

    // Opposing directions cancel before the 9-way direction code is chosen.
    function automatic logic [3:0] encode_dir(input logic up, input logic left,
                                              input logic down, input logic right);
        logic v_u;
        logic v_d;
        logic h_l;
        logic h_r;
        logic [3:0] kc;
        v_u = up & ~down;
        v_d = down & ~up;
        h_l = left & ~right;
        h_r = right & ~left;
        if (v_u && h_l)      kc = c_KC_UL;
        else if (v_u && h_r) kc = c_KC_UR;
        else if (v_d && h_l) kc = c_KC_DL;
        else if (v_d && h_r) kc = c_KC_DR;
        else if (v_u)        kc = c_KC_UP;
        else if (v_d)        kc = c_KC_DOWN;
        else if (h_l)        kc = c_KC_LEFT;
        else if (h_r)        kc = c_KC_RIGHT;
        else                 kc = c_KC_NONE;
        return kc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keycode_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : keycode_encoder_if
// Description : Scan-byte input and game-control output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface keycode_encoder_if;
    logic [7:0] scanCode;
    logic       scanValid;
    logic [1:0] gameState;
    logic [3:0] keycode;
    logic       keyPress;
    logic       Jumping;
    logic       Shooting;

    modport master (
        output scanCode, scanValid, gameState,
        input  keycode, keyPress, Jumping, Shooting
    );

    modport slave (
        input  scanCode, scanValid, gameState,
        output keycode, keyPress, Jumping, Shooting
    );
endinterface
`default_nettype wire

// File: rtl/ps2_prefix_parser.sv
`default_nettype none
// ============================================================================
// Module      : ps2_prefix_parser
// Description : Tracks F0/E0 prefixes and emits one event per key byte.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_prefix_parser
    import contra_input_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [7:0] i_scanCode,
    input  wire logic       i_scanValid,
    output logic            o_keyEvent,
    output logic            o_isBreak,
    output logic            o_isExt,
    output logic [7:0]      o_code
);

    localparam int              c_CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CW-1:0] c_TMAX = c_CW'(TIMEOUT_CYCLES - 1);

    prefix_state_t   r_state;
    prefix_state_t   w_state_next;
    logic [c_CW-1:0] r_cnt;
    logic            w_timeout;

    // A byte arriving on the expiry cycle wins over the timeout.
    assign w_timeout = (r_state != ST_IDLE) && (r_cnt == c_TMAX) && !i_scanValid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_scanValid) begin
            r_cnt <= '0;
        end else if (r_state != ST_IDLE && r_cnt != c_TMAX) begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_scanValid) begin
            if (i_scanCode == c_PFX_E0) begin
                w_state_next = ST_EXT;
            end else if (i_scanCode == c_PFX_F0) begin
                case (r_state)
                    ST_IDLE:  w_state_next = ST_BREAK;
                    ST_EXT:   w_state_next = ST_EXT_BREAK;
                    default:  w_state_next = r_state;
                endcase
            end else begin
                w_state_next = ST_IDLE;
            end
        end else if (w_timeout) begin
            w_state_next = ST_IDLE;
        end
    end

    always_comb begin
        o_keyEvent = i_scanValid && (i_scanCode != c_PFX_E0) && (i_scanCode != c_PFX_F0);
        o_isBreak  = (r_state == ST_BREAK) || (r_state == ST_EXT_BREAK);
        o_isExt    = (r_state == ST_EXT)   || (r_state == ST_EXT_BREAK);
        o_code     = i_scanCode;
    end

endmodule
`default_nettype wire

// File: rtl/keycode_encoder.sv
`default_nettype none
// ============================================================================
// Module      : keycode_encoder
// Description : Held-key tracking and direction/action encoding for gameplay.
// Revision    : 1.0 - initial release
// ============================================================================
module keycode_encoder
    import contra_input_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  wire logic         Clk,
    input  wire logic         Reset,
    keycode_encoder_if.slave  bus
);

    logic        w_keyEvent;
    logic        w_isBreak;
    logic        w_isExt;
    logic [7:0]  w_code;
    logic        w_set;

    held_flags_t r_flags;
    held_flags_t w_flags_next;
    logic [3:0]  w_keycode_next;
    logic        w_keyPress_next;

    logic [3:0]  r_keycode;
    logic        r_keyPress;
    logic        r_jumping;
    logic        r_shooting;

    ps2_prefix_parser #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_parser (
        .clk         (Clk),
        .rst         (Reset),
        .i_scanCode  (bus.scanCode),
        .i_scanValid (bus.scanValid),
        .o_keyEvent  (w_keyEvent),
        .o_isBreak   (w_isBreak),
        .o_isExt     (w_isExt),
        .o_code      (w_code)
    );

    assign w_set = ~w_isBreak;

    always_comb begin
        w_flags_next = r_flags;
        if (w_keyEvent) begin
            if (w_isExt) begin
                case (w_code)
                    c_SC_UP:    w_flags_next.up_a    = w_set;
                    c_SC_LEFT:  w_flags_next.left_a  = w_set;
                    c_SC_DOWN:  w_flags_next.down_a  = w_set;
                    c_SC_RIGHT: w_flags_next.right_a = w_set;
                    default:    w_flags_next = r_flags;
                endcase
            end else begin
                case (w_code)
                    c_SC_W:     w_flags_next.up_l    = w_set;
                    c_SC_A:     w_flags_next.left_l  = w_set;
                    c_SC_S:     w_flags_next.down_l  = w_set;
                    c_SC_D:     w_flags_next.right_l = w_set;
                    c_SC_SPACE: w_flags_next.jump    = w_set;
                    c_SC_J:     w_flags_next.shoot   = w_set;
                    default:    w_flags_next = r_flags;
                endcase
            end
        end
    end

    // Outputs are built from the next flag state so they land one cycle after the byte.
    always_comb begin
        w_keycode_next  = encode_dir(w_flags_next.up_a    | w_flags_next.up_l,
                                     w_flags_next.left_a  | w_flags_next.left_l,
                                     w_flags_next.down_a  | w_flags_next.down_l,
                                     w_flags_next.right_a | w_flags_next.right_l);
        w_keyPress_next = (w_keycode_next != c_KC_NONE) | w_flags_next.jump | w_flags_next.shoot;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_flags    <= '0;
            r_keycode  <= c_KC_NONE;
            r_keyPress <= 1'b0;
            r_jumping  <= 1'b0;
            r_shooting <= 1'b0;
        end else begin
            r_flags <= w_flags_next;
            if (bus.gameState == c_GS_PLAY) begin
                r_keycode  <= w_keycode_next;
                r_keyPress <= w_keyPress_next;
                r_jumping  <= w_flags_next.jump;
                r_shooting <= w_flags_next.shoot;
            end else begin
                r_keycode  <= c_KC_NONE;
                r_keyPress <= 1'b0;
                r_jumping  <= 1'b0;
                r_shooting <= 1'b0;
            end
        end
    end

    assign bus.keycode  = r_keycode;
    assign bus.keyPress = r_keyPress;
    assign bus.Jumping  = r_jumping;
    assign bus.Shooting = r_shooting;

endmodule
`default_nettype wire

// File: tb/tb_keycode_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_keycode_encoder
// Description : Directed scoreboard bench for keycode_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keycode_encoder;

    typedef struct {
        logic [3:0] kc;
        logic       kp;
        logic       j;
        logic       s;
        string      name;
    } exp_t;

    logic clk;
    logic rst;
    logic tb_chk;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    keycode_encoder_if bus();

    keycode_encoder #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [3:0] kc, input logic kp, input logic j,
                        input logic s, input string name);
        exp_t e;
        e.kc = kc; e.kp = kp; e.j = j; e.s = s; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] code, input logic [3:0] kc, input logic kp,
                        input logic j, input logic s, input string name);
        bus.scanCode  = code;
        bus.scanValid = 1'b1;
        push(kc, kp, j, s, name);
        @(negedge clk);
        bus.scanValid = 1'b0;
    endtask

    task automatic chk(input logic [3:0] kc, input logic kp, input logic j,
                       input logic s, input string name);
        tb_chk = 1'b1;
        push(kc, kp, j, s, name);
        @(negedge clk);
        tb_chk = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: any cycle carrying a byte or an explicit check is compared one edge later.
    initial begin
        logic sample;
        exp_t e;
        forever begin
            @(posedge clk);
            sample = bus.scanValid | tb_chk;
            @(negedge clk);
            if (sample) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: no expectation queued, keycode=%0d", bus.keycode);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.keycode !== e.kc || bus.keyPress !== e.kp ||
                        bus.Jumping !== e.j || bus.Shooting !== e.s) begin
                        errors++;
                        $display("FAIL %s: got kc=%0d kp=%b j=%b s=%b, expected kc=%0d kp=%b j=%b s=%b",
                                 e.name, bus.keycode, bus.keyPress, bus.Jumping, bus.Shooting,
                                 e.kc, e.kp, e.j, e.s);
                    end
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        tb_chk = 1'b0;
        bus.scanCode  = 8'h00;
        bus.scanValid = 1'b0;
        bus.gameState = 2'b01;
        idle(3);

        chk(4'd0, 0, 0, 0, "reset_state");
        rst = 1'b0;
        idle(1);

        // W, A -> up then up-left; release W -> left
        send(8'h1D, 4'd1, 1, 0, 0, "W_make");
        send(8'h1C, 4'd5, 1, 0, 0, "A_make_upleft");
        send(8'hF0, 4'd5, 1, 0, 0, "F0_hold");
        send(8'h1D, 4'd2, 1, 0, 0, "W_break_left");
        send(8'hF0, 4'd2, 1, 0, 0, "F0_a");
        send(8'h1C, 4'd0, 0, 0, 0, "A_break");

        // Left + right cancel
        send(8'h1C, 4'd2, 1, 0, 0, "A_make");
        send(8'h23, 4'd0, 0, 0, 0, "LR_cancel");
        send(8'hF0, 4'd0, 0, 0, 0, "F0_b");
        send(8'h1C, 4'd4, 1, 0, 0, "A_break_right");
        send(8'hF0, 4'd4, 1, 0, 0, "F0_c");
        send(8'h23, 4'd0, 0, 0, 0, "D_break");

        // Arrow and letter copies of up
        send(8'hE0, 4'd0, 0, 0, 0, "E0_a");
        send(8'h75, 4'd1, 1, 0, 0, "UPARROW_make");
        send(8'h1D, 4'd1, 1, 0, 0, "W_make_dup");
        send(8'hE0, 4'd1, 1, 0, 0, "E0_b");
        send(8'hF0, 4'd1, 1, 0, 0, "EF0");
        send(8'h75, 4'd1, 1, 0, 0, "UPARROW_break_still_up");
        send(8'hF0, 4'd1, 1, 0, 0, "F0_d");
        send(8'h1D, 4'd0, 0, 0, 0, "W_break_none");

        // Typematic repeat, arrow without E0, letter after E0
        send(8'h1B, 4'd3, 1, 0, 0, "S_make");
        send(8'h1B, 4'd3, 1, 0, 0, "S_repeat");
        send(8'hF0, 4'd3, 1, 0, 0, "F0_e");
        send(8'h72, 4'd3, 1, 0, 0, "arrow_no_ext_ignored");
        send(8'hE0, 4'd3, 1, 0, 0, "E0_c");
        send(8'h1B, 4'd3, 1, 0, 0, "letter_in_ext_ignored");
        send(8'hF0, 4'd3, 1, 0, 0, "F0_f");
        send(8'h1B, 4'd0, 0, 0, 0, "S_break");
        send(8'hF0, 4'd0, 0, 0, 0, "F0_g");
        send(8'h1C, 4'd0, 0, 0, 0, "break_not_held");

        // Jump and shoot
        send(8'h29, 4'd0, 1, 1, 0, "jump_make");
        send(8'hF0, 4'd0, 1, 1, 0, "F0_h");
        send(8'h29, 4'd0, 0, 0, 0, "jump_break");
        send(8'h3B, 4'd0, 1, 0, 1, "shoot_make");
        send(8'hE0, 4'd0, 1, 0, 1, "E0_d");
        send(8'h74, 4'd4, 1, 0, 1, "RIGHTARROW_make");
        send(8'hF0, 4'd4, 1, 0, 1, "F0_i");
        send(8'h3B, 4'd4, 1, 0, 0, "shoot_break");
        send(8'hE0, 4'd4, 1, 0, 0, "E0_e");
        send(8'hF0, 4'd4, 1, 0, 0, "EF0_b");
        send(8'hF0, 4'd4, 1, 0, 0, "EF0_repeat");
        send(8'h74, 4'd0, 0, 0, 0, "RIGHTARROW_break");

        // Unmapped bytes return the parser to IDLE
        send(8'hF0, 4'd0, 0, 0, 0, "F0_j");
        send(8'hAA, 4'd0, 0, 0, 0, "AA_unmapped");
        send(8'h1D, 4'd1, 1, 0, 0, "make_after_AA");
        send(8'hF0, 4'd1, 1, 0, 0, "F0_k");
        send(8'hFA, 4'd1, 1, 0, 0, "FA_unmapped");
        send(8'hF0, 4'd1, 1, 0, 0, "F0_l");
        send(8'h1D, 4'd0, 0, 0, 0, "W_break_after_FA");

        // Timeout: long wait turns the pending break into a make, short wait does not
        send(8'hF0, 4'd0, 0, 0, 0, "F0_timeout");
        idle(20);
        send(8'h1B, 4'd3, 1, 0, 0, "make_after_timeout");
        send(8'hF0, 4'd3, 1, 0, 0, "F0_short");
        idle(5);
        send(8'h1B, 4'd0, 0, 0, 0, "break_before_timeout");

        // Game-state gating
        send(8'h23, 4'd4, 1, 0, 0, "D_make");
        bus.gameState = 2'b10;
        chk(4'd0, 0, 0, 0, "gated_nonplay");
        bus.gameState = 2'b01;
        chk(4'd4, 1, 0, 0, "ungated_play");
        bus.gameState = 2'b00;
        send(8'hF0, 4'd0, 0, 0, 0, "gated_F0");
        send(8'h23, 4'd0, 0, 0, 0, "gated_D_break");
        bus.gameState = 2'b01;
        chk(4'd0, 0, 0, 0, "play_after_gated_break");

        // Reset mid-prefix, and reset beating a simultaneous byte
        send(8'h23, 4'd4, 1, 0, 0, "D_make_b");
        send(8'hF0, 4'd4, 1, 0, 0, "F0_before_reset");
        rst = 1'b1;
        chk(4'd0, 0, 0, 0, "reset_mid_prefix");
        rst = 1'b0;
        send(8'h23, 4'd4, 1, 0, 0, "make_after_reset");
        rst = 1'b1;
        send(8'h1D, 4'd0, 0, 0, 0, "reset_over_byte");
        rst = 1'b0;
        chk(4'd0, 0, 0, 0, "byte_discarded");

        idle(3);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
